seq_det_ctrl: RTL and testbench

Run-time programmable serial pattern detector with a controlling FSM. Software or an upstream sequencer loads a pattern (1..MAX_LEN bits), overlap mode, target match count and timeout, then starts a run. The block scans a qualified serial bitstream, counts matches, and ends the run on target, timeout or abort with a status code. It is the reusable, configurable replacement for the family of fixed-pattern detectors in the RTL sources.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_ctrl_if.sv | 41 ++++
 rtl/seq_det_core.sv | 56 +++++
 rtl/seq_det_ctrl.sv | 171 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the programmable serial pattern detector: controller
// state encoding and the done_reason codes reported at the end of a run.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] REASON_NONE    = 2'b00;
    localparam logic [1:0] REASON_TARGET  = 2'b01;
    localparam logic [1:0] REASON_TIMEOUT = 2'b10;
    localparam logic [1:0] REASON_ABORT   = 2'b11;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Bus bundle for seq_det_ctrl: configuration handshake, run control,
// qualified serial input and run status. The sequencer/software side is
// the master, the detector is the slave.
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
);
    localparam int LEN_W = $clog2(MAX_LEN);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in;
    logic               armed;
    logic               busy;
    logic               done;
    logic [1:0]         done_reason;
    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output start, abort, in_valid, in,
        input  cfg_ready, armed, busy, done, done_reason, match_pulse, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  start, abort, in_valid, in,
        output cfg_ready, armed, busy, done, done_reason, match_pulse, match_count
    );

endinterface

// File: rtl/seq_det_core.sv
// Pattern matching datapath: history shift register, fill counter and a
// length-masked compare of {history, bit_in} against the pattern.
// bit 0 of the window is the newest bit. The match output is combinational
// and only asserts on a shift cycle.
module seq_det_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W:0]     fill;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    assign window = {hist, bit_in};

    // Mask selects the low len+1 bits of the window for comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i <= int'(len));
        end
    end

    assign match = shift_en && (fill >= {1'b0, len}) && (((window ^ pattern) & mask) == '0);

    // Shift history on qualified bits; fill saturates at the pattern length
    // and restarts after a match when overlapping matches are disallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[MAX_LEN-2:0];
            if (match && !overlap) begin
                fill <= '0;
            end else if (fill <= {1'b0, len}) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-time programmable serial pattern detector: controller FSM, shadow
// configuration, match counter and run status.
// Optional feature: define SEQ_DET_CTRL_TIMEOUT_EN to include the run
// timeout counter (done_reason 10). Without it cfg_timeout is ignored.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset, waiting for a configuration
// ARMED | configuration held, waiting for start (or abort)
// RUN   | scanning the serial stream and counting matches
// DONE  | run ended, count and reason held; rerun or reconfigure
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    seq_det_ctrl_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [1:0]         reason_q;
    logic               pulse_q;
    logic               cfg_take;
    logic               start_go;
    logic               shift_en;
    logic               core_match;
    logic               target_hit;
    logic               tmo_hit;

    // A simultaneous cfg handshake wins over start in DONE; abort wins over start in ARMED.
    assign cfg_take   = bus.cfg_valid && (state == IDLE || state == DONE);
    assign start_go   = bus.start && ((state == ARMED && !bus.abort) ||
                                      (state == DONE  && !bus.cfg_valid));
    assign shift_en   = (state == RUN) && bus.in_valid && !bus.abort;
    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign target_hit = core_match && (tgt_q != '0) && (cnt_inc == tgt_q);

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cfg_q;
    logic [TMO_W-1:0] tmo_cnt_q;

    // Down-counter loaded with timeout-1 at start; terminal count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cfg_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (cfg_take) begin
                tmo_cfg_q <= bus.cfg_timeout;
            end
            if (start_go) begin
                tmo_cnt_q <= tmo_cfg_q - 1'b1;
            end else if (state == RUN && tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end
        end
    end

    assign tmo_hit = (state == RUN) && (tmo_cfg_q != '0) && (tmo_cnt_q == '0);
`else
    logic [TMO_W-1:0] unused_tmo;

    assign unused_tmo = bus.cfg_timeout;
    assign tmo_hit    = 1'b0;
`endif

    // Shadow configuration captured on the cfg handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
            tgt_q <= '0;
        end else if (cfg_take) begin
            pat_q <= bus.cfg_pattern;
            len_q <= bus.cfg_len;
            ovl_q <= bus.cfg_overlap;
            tgt_q <= bus.cfg_target;
        end
    end

    seq_det_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_go),
        .shift_en (shift_en),
        .bit_in   (bus.in),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .match    (core_match)
    );

    // Run-control FSM with match counter, pulse and end-of-run reason.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt_q    <= '0;
            reason_q <= REASON_NONE;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_take) state <= ARMED;
                end
                ARMED: begin
                    if (bus.abort) begin
                        state    <= DONE;
                        reason_q <= REASON_ABORT;
                    end else if (start_go) begin
                        state    <= RUN;
                        cnt_q    <= '0;
                        reason_q <= REASON_NONE;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state    <= DONE;
                        reason_q <= REASON_ABORT;
                    end else begin
                        if (core_match) begin
                            pulse_q <= 1'b1;
                            cnt_q   <= cnt_inc;
                        end
                        if (target_hit) begin
                            state    <= DONE;
                            reason_q <= REASON_TARGET;
                        end else if (tmo_hit) begin
                            state    <= DONE;
                            reason_q <= REASON_TIMEOUT;
                        end
                    end
                end
                DONE: begin
                    if (cfg_take) begin
                        state <= ARMED;
                    end else if (start_go) begin
                        state    <= RUN;
                        cnt_q    <= '0;
                        reason_q <= REASON_NONE;
                    end
                end
            endcase
        end
    end

    assign bus.cfg_ready   = (state == IDLE) || (state == DONE);
    assign bus.armed       = (state == ARMED);
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.done_reason = reason_q;
    assign bus.match_pulse = pulse_q;
    assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Testbench for seq_det_ctrl: directed scenarios plus a randomized stream,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int TMO_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Behavioural model: phase 0 idle, 1 armed, 2 run, 3 done.
    int         m_st;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_tgt;
    int         m_tmo;
    int         m_cnt;
    int         m_reason;
    int         m_el;
    bit         m_pulse;
    bit         m_q[$];

    task automatic model_load();
        m_pat = bus.cfg_pattern;
        m_len = int'(bus.cfg_len) + 1;
        m_ovl = bus.cfg_overlap;
        m_tgt = int'(bus.cfg_target);
        m_tmo = int'(bus.cfg_timeout);
        m_st  = 1;
    endtask

    task automatic model_begin();
        m_q.delete();
        m_cnt    = 0;
        m_reason = 0;
        m_el     = 0;
        m_st     = 2;
    endtask

    task automatic model_edge();
        bit hit;
        m_pulse = 0;
        case (m_st)
            0: if (bus.cfg_valid) model_load();
            1: begin
                if (bus.abort) begin m_st = 3; m_reason = 3; end
                else if (bus.start) model_begin();
            end
            2: begin
                if (bus.abort) begin
                    m_st = 3; m_reason = 3;
                end else begin
                    hit = 0;
                    if (bus.in_valid) begin
                        m_q.push_back(bus.in);
                        if (m_q.size() > m_len) void'(m_q.pop_front());
                        if (m_q.size() == m_len) begin
                            hit = 1;
                            for (int i = 0; i < m_len; i++)
                                if (m_q[i] != m_pat[m_len-1-i]) hit = 0;
                        end
                        if (hit && !m_ovl) m_q.delete();
                    end
                    if (hit) begin
                        m_pulse = 1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end
                    if (hit && m_tgt != 0 && m_cnt == m_tgt) begin
                        m_st = 3; m_reason = 1;
                    end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
                    else if (m_tmo != 0 && m_el == m_tmo - 1) begin
                        m_st = 3; m_reason = 2;
                    end
`endif
                    m_el++;
                end
            end
            default: begin
                if (bus.cfg_valid) model_load();
                else if (bus.start) model_begin();
            end
        endcase
    endtask

    task automatic compare();
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_st == 0 || m_st == 3));
        chk("state", 32'({bus.armed, bus.busy, bus.done}), 32'({m_st == 1, m_st == 2, m_st == 3}));
        chk("done_reason", 32'(bus.done_reason), 32'(m_reason));
        chk("match_pulse", 32'(bus.match_pulse), 32'(m_pulse));
        chk("match_count", 32'(bus.match_count), 32'(m_cnt));
    endtask

    task automatic cyc(input bit cv, input bit st, input bit ab, input bit iv, input bit b);
        bus.cfg_valid = cv;
        bus.start     = st;
        bus.abort     = ab;
        bus.in_valid  = iv;
        bus.in        = b;
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = 1'b0;
        #2;
        m_st = 0; m_cnt = 0; m_reason = 0; m_pulse = 0; m_el = 0;
        m_q.delete();
        compare();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic load_cfg(input logic [7:0] pat, input int lm1, input bit ovl, input int tgt, input int tmo);
        bus.cfg_pattern = pat;
        bus.cfg_len     = 3'(lm1);
        bus.cfg_overlap = ovl;
        bus.cfg_target  = 8'(tgt);
        bus.cfg_timeout = 16'(tmo);
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(0, 0, 0, 1, v[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] gp;

        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.cfg_timeout = '0;
        do_reset();

        // start in IDLE is ignored
        cyc(0, 1, 0, 0, 0);
        chk("idle_start_busy", 32'(bus.busy), 32'd0);

        // 0011, overlap, target 2
        load_cfg(8'b0011, 3, 1, 2, 0);
        chk("t1_armed", 32'(bus.armed), 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send_bits(32'b0011, 4);
        chk("t1_pulse4", 32'(bus.match_pulse), 32'd1);
        send_bits(32'b0011, 4);
        chk("t1_pulse8", 32'(bus.match_pulse), 32'd1);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_reason", 32'(bus.done_reason), 32'd1);
        chk("t1_count", 32'(bus.match_count), 32'd2);

        // rerun from DONE clears count; abort on a matching bit
        cyc(0, 1, 0, 0, 0);
        chk("rerun_busy", 32'(bus.busy), 32'd1);
        chk("rerun_count", 32'(bus.match_count), 32'd0);
        send_bits(32'b001, 3);
        cyc(0, 0, 1, 1, 1);
        chk("abort_done", 32'(bus.done), 32'd1);
        chk("abort_reason", 32'(bus.done_reason), 32'd3);
        chk("abort_count", 32'(bus.match_count), 32'd0);
        chk("abort_pulse", 32'(bus.match_pulse), 32'd0);

        // 101 with and without overlap
        load_cfg(8'b101, 2, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        send_bits(32'b10101, 5);
        chk("t2_ovl_count", 32'(bus.match_count), 32'd2);
        cyc(0, 0, 1, 0, 0);
        load_cfg(8'b101, 2, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        send_bits(32'b10101, 5);
        chk("t2_novl_count", 32'(bus.match_count), 32'd1);

        // cfg offered during RUN is refused and has no effect
        bus.cfg_pattern = 8'hFF;
        bus.cfg_len     = 3'd7;
        bus.cfg_overlap = 1'b1;
        bus.cfg_target  = 8'd1;
        cyc(1, 0, 0, 0, 0);
        chk("run_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        send_bits(32'b101, 3);
        chk("run_cfg_kept", 32'(bus.match_count), 32'd2);
        chk("run_cfg_busy", 32'(bus.busy), 32'd1);

        // reset mid-run
        do_reset();
        chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("rst_start_ignored", 32'(bus.busy), 32'd0);

        // timeout behaviour
        load_cfg(8'b11, 1, 0, 0, 10);
        cyc(0, 1, 0, 0, 0);
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        repeat (9) cyc(0, 0, 0, 1, 0);
        chk("tmo_busy9", 32'(bus.busy), 32'd1);
        cyc(0, 0, 0, 1, 0);
        chk("tmo_done", 32'(bus.done), 32'd1);
        chk("tmo_reason", 32'(bus.done_reason), 32'd2);
        chk("tmo_count", 32'(bus.match_count), 32'd0);
`else
        repeat (40) cyc(0, 0, 0, 1, 0);
        chk("notmo_busy", 32'(bus.busy), 32'd1);
        chk("notmo_reason", 32'(bus.done_reason), 32'd0);
        cyc(0, 0, 1, 0, 0);
`endif

        // 8-bit pattern A5 with in_valid gaps
        load_cfg(8'hA5, 7, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        gp = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 1'($urandom));
            cyc(0, 0, 0, 1, gp[i]);
            if (i == 1) chk("gap_count7", 32'(bus.match_count), 32'd0);
        end
        chk("gap_pulse8", 32'(bus.match_pulse), 32'd1);
        chk("gap_count8", 32'(bus.match_count), 32'd1);
        cyc(0, 0, 1, 0, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.cfg_pattern = 8'($urandom);
                bus.cfg_len     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                              : 3'($urandom_range(0, 3));
                bus.cfg_overlap = 1'($urandom);
                bus.cfg_target  = 8'($urandom_range(0, 3));
                bus.cfg_timeout = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(3, 40)) : 16'd0;
            end
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
